// File: rtl/diferenciador.sv
// Stream differentiator: delta = x[n] - x[n-1] with a registered valid/ready output.
// Define DIFERENCIADOR_WRAP_EN to take the difference modulo 2^W (inverts a wrapping accumulator).
module diferenciador #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic signed [W-1:0]  x,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 restart,
  output logic signed [W:0]    delta,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 first,
  output logic [CNT_W-1:0]     cnt
);

  typedef enum logic [1:0] {
    ZERO         = 2'd0,
    RUN          = 2'd1,
    PRIME        = 2'd2,
    PRIMED_FIRST = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] prev_q, prev_d;
  logic signed [W:0]   delta_q, delta_d;
  logic                out_valid_q, out_valid_d;
  logic                first_q, first_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                pop;
  logic signed [W-1:0] base;
  logic signed [W:0]   diff;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  // ZERO means the history is the cleared accumulator, so subtract 0.
  assign base = (state_q == ZERO) ? '0 : prev_q;

`ifdef DIFERENCIADOR_WRAP_EN
  logic signed [W-1:0] diff_w;
  assign diff_w = x - base;
  assign diff   = {diff_w[W-1], diff_w};
`else
  assign diff = {x[W-1], x} - {base[W-1], base};
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    delta_d     = delta_q;
    first_d     = first_q;
    out_valid_d = out_valid_q && !pop;
    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, pop};

    if (restart) begin
      // A sample accepted alongside restart only seeds the history.
      state_d = PRIME;
      if (accept) begin
        prev_d  = x;
        state_d = PRIMED_FIRST;
      end
    end else begin
      case (state_q)
        ZERO: begin
          if (accept) begin
            delta_d     = diff;
            out_valid_d = 1'b1;
            first_d     = 1'b1;
            prev_d      = x;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            delta_d     = diff;
            out_valid_d = 1'b1;
            first_d     = 1'b0;
            prev_d      = x;
          end
        end
        PRIME: begin
          if (accept) begin
            prev_d  = x;
            state_d = PRIMED_FIRST;
          end
        end
        PRIMED_FIRST: begin
          if (accept) begin
            delta_d     = diff;
            out_valid_d = 1'b1;
            first_d     = 1'b1;
            prev_d      = x;
            state_d     = RUN;
          end
        end
        default: state_d = ZERO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ZERO;
      prev_q      <= '0;
      delta_q     <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      delta_q     <= delta_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
    end
  end

  assign delta     = delta_q;
  assign out_valid = out_valid_q;
  assign first     = first_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_diferenciador.sv
// Scoreboard bench for diferenciador (W=4, CNT_W=8): directed samples push expected deltas,
// a monitor pops and compares on every output handshake.
module tb_diferenciador;

  logic              clk;
  logic              clr_n;
  logic signed [3:0] x;
  logic              in_valid;
  logic              in_ready;
  logic              restart;
  logic signed [4:0] delta;
  logic              out_valid;
  logic              out_ready;
  logic              first;
  logic [7:0]        cnt;

  typedef struct {
    int d;
    int f;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  diferenciador #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .restart   (restart),
    .delta     (delta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .first     (first),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one sample; wait (bounded) for acceptance; optionally queue its expected delta.
  task automatic applyStimulus(input int sx, input logic rs, input logic exp_out,
                               input int exp_d, input int exp_f);
    logic ok;
    x        = 4'(sx);
    in_valid = 1'b1;
    restart  = rs;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready never rose for x=%0d", sx);
    end
    if (exp_out) sb_q.push_back('{d: exp_d, f: exp_f});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
    if (exp_out && ok) checkOutput("latency_out_valid", int'(out_valid), 1);
  endtask

  task automatic drainQueue();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d expected deltas never appeared", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    drainQueue();
    @(negedge clk);
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got delta=%0d, expected no output", delta);
        end else begin
          e = sb_q.pop_front();
          checkOutput("delta", int'(delta), e.d);
          checkOutput("first", int'(first), e.f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr_n     = 1'b0;
    x         = '0;
    in_valid  = 1'b0;
    restart   = 1'b0;
    out_ready = 1'b1;
    #12;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_delta", int'(delta), 0);
    checkOutput("reset_first", int'(first), 0);
    checkOutput("reset_cnt", int'(cnt), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    #1;
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic pair");
    applyStimulus(2, 1'b0, 1'b1, 2, 1);
    applyStimulus(5, 1'b0, 1'b1, 3, 0);
    drainQueue();
    checkOutput("cnt_after_pair", int'(cnt), 2);

    $display("[TB] back-to-back sequence");
    doReset();
    applyStimulus(0, 1'b0, 1'b1, 0, 1);
    applyStimulus(3, 1'b0, 1'b1, 3, 0);
    applyStimulus(-3, 1'b0, 1'b1, -6, 0);
    applyStimulus(-3, 1'b0, 1'b1, 0, 0);
    drainQueue();
    checkOutput("cnt_after_seq", int'(cnt), 4);

    $display("[TB] extreme step 7 -> -8");
    doReset();
    applyStimulus(7, 1'b0, 1'b1, 7, 1);
`ifdef DIFERENCIADOR_WRAP_EN
    applyStimulus(-8, 1'b0, 1'b1, 1, 0);
`else
    applyStimulus(-8, 1'b0, 1'b1, -15, 0);
`endif
    drainQueue();

    $display("[TB] backpressure");
    doReset();
    out_ready = 1'b0;
    applyStimulus(4, 1'b0, 1'b1, 4, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_delta", int'(delta), 4);
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(6, 1'b0, 1'b1, 2, 0);
    drainQueue();
    checkOutput("cnt_after_bp", int'(cnt), 2);

    $display("[TB] restart priming");
    applyStimulus(5, 1'b1, 1'b0, 0, 0);
    checkOutput("prime_no_output", int'(out_valid), 0);
    applyStimulus(-2, 1'b0, 1'b1, -7, 1);
    applyStimulus(1, 1'b0, 1'b1, 3, 0);
    drainQueue();
    checkOutput("cnt_after_restart", int'(cnt), 4);

    $display("[TB] asynchronous clear with pending delta");
    out_ready = 1'b0;
    applyStimulus(3, 1'b0, 1'b0, 0, 0);
    checkOutput("pend_out_valid", int'(out_valid), 1);
    checkOutput("pend_delta", int'(delta), 2);
    checkOutput("pend_cnt", int'(cnt), 4);
    #2;
    clr_n = 1'b0;
    #1;
    checkOutput("async_out_valid", int'(out_valid), 0);
    checkOutput("async_delta", int'(delta), 0);
    checkOutput("async_cnt", int'(cnt), 0);
    checkOutput("async_first", int'(first), 0);
    @(negedge clk);
    #1;
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(3, 1'b0, 1'b1, 3, 1);
    drainQueue();
    checkOutput("cnt_after_clear", int'(cnt), 1);

    $display("[TB] counter wrap");
    doReset();
    for (int i = 0; i < 257; i++) begin
      applyStimulus(0, 1'b0, 1'b1, 0, (i == 0) ? 1 : 0);
    end
    drainQueue();
    checkOutput("cnt_wrap", int'(cnt), 1);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
